// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and fetch entry layout for the instruction fetch unit
//
// Purpose : default architectural width, reset fetch address and the layout of one
//           buffered fetch entry {pc, inst, err} as it travels through the prefetch FIFO.
// Ports   : none (package).
package ifu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    // Entry layout at the default width; the top packs the same fields in this order.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            err;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - redirect, memory bus and decode-side handshake bundle
//
// Purpose : groups every handshake signal of the prefetch unit.
// Signals : redirect_valid/redirect_pc   EXU flush and new fetch PC
//           mem_req_valid/ready/addr      word fetch request channel
//           mem_rsp_valid/data/err        in-order response channel (always accepted)
//           out_valid/ready/pc/inst/err   buffered instruction towards the IDU
// Modports: master = fetch unit, slave = its environment (EXU, memory, IDU).
interface ifu_prefetch_if
    import ifu_pkg::*;
#(
    parameter int XLEN = ifu_pkg::XLEN
) ();

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            mem_rsp_err;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_err;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr,
        output out_valid, out_pc, out_inst, out_err
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output out_ready,
        input  mem_req_valid, mem_req_addr,
        input  out_valid, out_pc, out_inst, out_err
    );

endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - shift-register FIFO with flush, occupancy count and registered head
//
// Purpose : buffers fetch entries; entry 0 is always the head, so the head is a flop.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           flush             drop every entry (wins over push and pop)
//           push, din         write one entry
//           pop               remove the head (ignored when empty)
//           count             number of valid entries
//           head_valid, head  registered head entry
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slots [DEPTH];
    logic             do_pop;
    logic             do_push;
    logic [CW-1:0]    wr_idx;

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (do_pop || (count != CW'(DEPTH)));
    // On a simultaneous pop the tail moves down one slot before the write lands.
    assign wr_idx  = do_pop ? (count - CW'(1)) : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slots[i] <= slots[i + 1];
                end
            end
            if (do_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        slots[i] <= din;
                    end
                end
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head       = slots[0];
    assign head_valid = (count != '0);

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetcher with redirect flush
//
// Purpose : issues word fetches from fetch_pc, keeps at most MAX_OUT requests in
//           flight, buffers responses in a DEPTH-entry FIFO and presents {pc,inst,err}
//           to the decoder. A redirect flushes the FIFO and marks every in-flight
//           response as stale.
// Ports   : clk   clock, rising edge
//           rst   asynchronous active-high reset
//           bus   ifu_prefetch_if.master (redirect, memory request/response, output)
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = ifu_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::RESET_PC
) (
    input  logic           clk,
    input  logic           rst,
    ifu_prefetch_if.master bus
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int EW = 2 * XLEN + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_base;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   in_use;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [EW-1:0]   head;

    assign redirect_base = bus.redirect_pc & ~XLEN'(3);

    // Buffered plus in-flight entries; stale responses still hold a slot until they return.
    assign in_use = SW'(fifo_count) + SW'(outstanding);

    // Only reserves space that is guaranteed free, so no response ever needs back-pressure.
    // The operands only grow on an accepted request, so valid holds until ready.
    assign bus.mem_req_valid = !rst && !bus.redirect_valid &&
                               (outstanding < OW'(MAX_OUT)) && (in_use < SW'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_fire = bus.mem_rsp_valid;
    assign outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_fire);

    assign push = rsp_fire && (drop == '0) && !bus.redirect_valid;
    assign pop  = head_valid && bus.out_ready;

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .push       (push),
        .din        ({rsp_pc, bus.mem_rsp_data, bus.mem_rsp_err}),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head[EW-1 -: XLEN];
    assign bus.out_inst  = head[XLEN -: XLEN];
    assign bus.out_err   = head[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                // Everything still in flight after this cycle belongs to the old stream.
                drop     <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (rsp_fire && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

    rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.XLEN(32)) bus ();

    ifu_prefetch #(
        .XLEN     (32),
        .DEPTH    (4),
        .MAX_OUT  (2),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ncyc;
    int          lat;
    int          max_inflight;
    logic        err_en;
    logic [31:0] err_addr;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] req_log   [$];
    logic [31:0] pop_pc    [$];
    logic [31:0] pop_inst  [$];
    logic        pop_err   [$];
    int          pop_cyc   [$];

    // Memory returns ~addr as the instruction, in order, lat cycles after acceptance.
    task automatic step();
        logic [31:0] a;
        int          rsp_now;
        rsp_now = 0;
        if (pend_addr.size() > 0 && pend_due[0] <= ncyc + 1) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = ~a;
            bus.mem_rsp_err   = err_en && (a == err_addr);
            rsp_now = 1;
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
            bus.mem_rsp_err   = 1'b0;
        end
        #1;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            pend_addr.push_back(bus.mem_req_addr);
            pend_due.push_back(ncyc + 1 + lat);
            req_log.push_back(bus.mem_req_addr);
            if (pend_addr.size() + rsp_now > max_inflight) max_inflight = pend_addr.size() + rsp_now;
        end
        if (bus.out_valid && bus.out_ready) begin
            pop_pc.push_back(bus.out_pc);
            pop_inst.push_back(bus.out_inst);
            pop_err.push_back(bus.out_err);
            pop_cyc.push_back(ncyc);
        end
        @(posedge clk);
        ncyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.mem_rsp_err    = 1'b0;
        bus.out_ready      = 1'b0;
        pend_addr.delete(); pend_due.delete(); req_log.delete();
        pop_pc.delete(); pop_inst.delete(); pop_err.delete(); pop_cyc.delete();
        lat = 1; err_en = 1'b0; err_addr = '0; max_inflight = 0; ncyc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); n_fail++; end
        n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); n_fail++; end
        n_checks++; if (bus.out_pc !== 32'h0) begin $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); n_fail++; end
        n_checks++; if (bus.out_inst !== 32'h0) begin $display("FAIL reset_out_inst: got %h want 0", bus.out_inst); n_fail++; end
        n_checks++; if (bus.out_err !== 1'b0) begin $display("FAIL reset_out_err: got %b want 0", bus.out_err); n_fail++; end
        @(negedge clk);
        do_reset();
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin $display("FAIL first_req_valid: got %b want 1", bus.mem_req_valid); n_fail++; end
        n_checks++; if (bus.mem_req_addr !== 32'h8000_0000) begin $display("FAIL first_req_addr: got %h want 80000000", bus.mem_req_addr); n_fail++; end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0000;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL redirect_blocks_req: got %b want 0", bus.mem_req_valid); n_fail++; end
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++; if (req_log.size() !== 0) begin $display("FAIL redirect_cycle_req_count: got %0d want 0", req_log.size()); n_fail++; end
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin $display("FAIL resume_after_redirect: got %b want 1", bus.mem_req_valid); n_fail++; end
    endtask

    task automatic test_req_hold();
        do_reset();
        bus.mem_req_ready = 1'b0;
        repeat (3) step();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000) begin
            $display("FAIL hold_req: got valid=%b addr=%h want 1 80000000", bus.mem_req_valid, bus.mem_req_addr); n_fail++; end
        n_checks++; if (req_log.size() !== 0) begin $display("FAIL hold_no_fire: got %0d want 0", req_log.size()); n_fail++; end
        bus.mem_req_ready = 1'b1;
        step();
        n_checks++; if (req_log.size() !== 1 || bus.mem_req_addr !== 32'h8000_0004) begin
            $display("FAIL hold_release: got n=%0d addr=%h want 1 80000004", req_log.size(), bus.mem_req_addr); n_fail++; end
    endtask

    task automatic test_sequential();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (20) step();
        n_checks++; if (req_log.size() < 8 || pop_pc.size() < 8) begin
            $display("FAIL seq_counts: got req=%0d pop=%0d want >=8 each", req_log.size(), pop_pc.size()); n_fail++; end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (req_log[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    $display("FAIL seq_addr[%0d]: got %h want %h", i, req_log[i], 32'h8000_0000 + 32'(4 * i)); n_fail++; end
                n_checks++; if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i) || pop_inst[i] !== ~(32'h8000_0000 + 32'(4 * i)) || pop_err[i] !== 1'b0) begin
                    $display("FAIL seq_out[%0d]: got pc=%h inst=%h err=%b", i, pop_pc[i], pop_inst[i], pop_err[i]); n_fail++; end
            end
            n_checks++; if (pop_cyc[0] !== 2) begin $display("FAIL seq_latency: got first pop cycle %0d want 2", pop_cyc[0]); n_fail++; end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) step();
        n_checks++; if (req_log.size() !== 4) begin $display("FAIL bp_req_count: got %0d want 4", req_log.size()); n_fail++; end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL bp_req_stalled: got %b want 0", bus.mem_req_valid); n_fail++; end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000) begin
            $display("FAIL bp_head: got valid=%b pc=%h want 1 80000000", bus.out_valid, bus.out_pc); n_fail++; end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        repeat (6) step();
        n_checks++; if (req_log.size() !== 5) begin $display("FAIL bp_one_refill: got %0d want 5", req_log.size()); n_fail++; end
        else begin
            n_checks++; if (req_log[4] !== 32'h8000_0010) begin $display("FAIL bp_refill_addr: got %h want 80000010", req_log[4]); n_fail++; end
        end
        n_checks++; if (pop_pc.size() !== 1 || bus.out_pc !== 32'h8000_0004) begin
            $display("FAIL bp_after_pop: got pops=%0d head=%h want 1 80000004", pop_pc.size(), bus.out_pc); n_fail++; end
    endtask

    task automatic test_latency();
        do_reset();
        lat = 3;
        bus.out_ready = 1'b1;
        repeat (30) step();
        n_checks++; if (max_inflight !== 2) begin $display("FAIL lat_max_outstanding: got %0d want 2", max_inflight); n_fail++; end
        n_checks++; if (pop_pc.size() < 6) begin $display("FAIL lat_pop_count: got %0d want >=6", pop_pc.size()); n_fail++; end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i) || pop_inst[i] !== ~(32'h8000_0000 + 32'(4 * i))) begin
                    $display("FAIL lat_order[%0d]: got pc=%h inst=%h", i, pop_pc[i], pop_inst[i]); n_fail++; end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        repeat (6) step();
        n_checks++; if (req_log.size() !== 4 || bus.out_valid !== 1'b1) begin
            $display("FAIL redir_setup: got req=%0d out_valid=%b want 4 1", req_log.size(), bus.out_valid); n_fail++; end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL redir_flush: got out_valid=%b want 0", bus.out_valid); n_fail++; end
        bus.out_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (pop_pc.size() !== 0 || bus.out_valid !== 1'b0) begin
            $display("FAIL redir_stale_hidden: got pops=%0d out_valid=%b want 0 0", pop_pc.size(), bus.out_valid); n_fail++; end
        repeat (11) step();
        n_checks++; if (req_log.size() < 5 || req_log[4] !== 32'h8000_0100) begin
            $display("FAIL redir_next_addr: got n=%0d addr=%h want 80000100", req_log.size(), req_log[4]); n_fail++; end
        n_checks++; if (pop_pc.size() < 2) begin $display("FAIL redir_pop_count: got %0d want >=2", pop_pc.size()); n_fail++; end
        else begin
            n_checks++; if (pop_pc[0] !== 32'h8000_0100 || pop_inst[0] !== ~32'h8000_0100) begin
                $display("FAIL redir_first_out: got pc=%h inst=%h want 80000100 7ffffeff", pop_pc[0], pop_inst[0]); n_fail++; end
            n_checks++; if (pop_pc[1] !== 32'h8000_0104) begin $display("FAIL redir_second_out: got %h want 80000104", pop_pc[1]); n_fail++; end
        end
    endtask

    task automatic test_redirect_collide();
        int found;
        int base;
        do_reset();
        lat = 2;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (pend_addr.size() == 2 && pend_due[0] <= ncyc + 1 && bus.out_valid === 1'b1) found = 1;
            else step();
        end
        n_checks++; if (found != 1) begin $display("FAIL collide_setup: got found=%0d want 1", found); n_fail++; end
        base = pop_pc.size() + 1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL collide_no_stale: got out_valid=%b want 0", bus.out_valid); n_fail++; end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL collide_drop_one: got out_valid=%b want 0", bus.out_valid); n_fail++; end
        repeat (12) step();
        n_checks++; if (pop_pc.size() < base + 2) begin $display("FAIL collide_pop_count: got %0d want >=%0d", pop_pc.size(), base + 2); n_fail++; end
        else begin
            n_checks++; if (pop_pc[base] !== 32'h8000_0200 || pop_inst[base] !== ~32'h8000_0200) begin
                $display("FAIL collide_first_out: got pc=%h inst=%h want 80000200 7ffffdff", pop_pc[base], pop_inst[base]); n_fail++; end
            n_checks++; if (pop_pc[base + 1] !== 32'h8000_0204 || pop_inst[base + 1] !== ~32'h8000_0204) begin
                $display("FAIL collide_second_out: got pc=%h inst=%h want 80000204", pop_pc[base + 1], pop_inst[base + 1]); n_fail++; end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 3;
        bus.out_ready = 1'b1;
        repeat (2) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        step();
        bus.redirect_pc    = 32'hFFFF_FFFB;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (req_log.size() !== 2) begin $display("FAIL b2b_no_req: got %0d want 2", req_log.size()); n_fail++; end
        repeat (14) step();
        n_checks++; if (req_log.size() < 5 || req_log[2] !== 32'hFFFF_FFF8 || req_log[3] !== 32'hFFFF_FFFC || req_log[4] !== 32'h0) begin
            $display("FAIL b2b_wrap_addrs: got n=%0d %h %h %h want fffffff8 fffffffc 00000000", req_log.size(), req_log[2], req_log[3], req_log[4]); n_fail++; end
        n_checks++; if (pop_pc.size() < 3) begin $display("FAIL b2b_pop_count: got %0d want >=3", pop_pc.size()); n_fail++; end
        else begin
            n_checks++; if (pop_pc[0] !== 32'hFFFF_FFF8 || pop_inst[0] !== 32'h0000_0007) begin
                $display("FAIL b2b_first_out: got pc=%h inst=%h want fffffff8 00000007", pop_pc[0], pop_inst[0]); n_fail++; end
            n_checks++; if (pop_pc[1] !== 32'hFFFF_FFFC || pop_pc[2] !== 32'h0 || pop_inst[2] !== 32'hFFFF_FFFF) begin
                $display("FAIL b2b_wrap_out: got %h %h inst=%h want fffffffc 00000000 ffffffff", pop_pc[1], pop_pc[2], pop_inst[2]); n_fail++; end
        end
    endtask

    task automatic test_error();
        do_reset();
        err_en   = 1'b1;
        err_addr = 32'h8000_0004;
        bus.out_ready = 1'b1;
        repeat (12) step();
        n_checks++; if (pop_pc.size() < 4) begin $display("FAIL err_pop_count: got %0d want >=4", pop_pc.size()); n_fail++; end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i) || pop_inst[i] !== ~(32'h8000_0000 + 32'(4 * i)) || pop_err[i] !== (i == 1)) begin
                    $display("FAIL err_entry[%0d]: got pc=%h inst=%h err=%b want err=%b", i, pop_pc[i], pop_inst[i], pop_err[i], (i == 1)); n_fail++; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_req_hold();
        test_sequential();
        test_backpressure();
        test_latency();
        test_redirect();
        test_redirect_collide();
        test_back_to_back();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
